// File: rtl/nw_flit_fifo.sv
// Flit FIFO for a network link: circular buffer with a registered credit return and a sticky overflow flag.
// Optional same-cycle bypass of an empty FIFO is enabled by defining NW_FLIT_FIFO_BYPASS_EN.
module nw_flit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             credit_out,
    output logic [CW-1:0]    count,
    output logic             overflow_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_credit;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_bypass_take;
    logic w_store;
    logic w_deq;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

`ifdef NW_FLIT_FIFO_BYPASS_EN
    // An offered flit is presented straight to the output while nothing is stored ahead of it.
    assign w_bypass  = w_empty & in_valid;
    assign out_valid = ~w_empty | w_bypass;
    assign out_data  = w_bypass ? in_data : r_mem[r_rd_ptr];
`else
    assign w_bypass  = 1'b0;
    assign out_valid = ~w_empty;
    assign out_data  = r_mem[r_rd_ptr];
`endif

    assign in_ready      = ~w_full;
    assign w_push        = in_valid & ~w_full;
    assign w_pop         = out_valid & out_ready;
    assign w_bypass_take = w_bypass & out_ready;
    assign w_store       = w_push & ~w_bypass_take;
    assign w_deq         = w_pop & ~w_bypass_take;

    assign credit_out   = r_credit;
    assign count        = r_count;
    assign overflow_err = r_overflow;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_credit <= w_pop;
            if (in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_store) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_deq) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_store, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/nw_flit_fifo.md
NW_FLIT_FIFO -- requirements
Module: nw_flit_fifo

Interface
REQ-001 Parameter: WIDTH, 32, flit width in bits.
REQ-002 Parameter: DEPTH, 4, flit storage entries; legal range 2..64; need not be a power of two.
REQ-003 Parameter: CW, $clog2(DEPTH+1), width of the count output.
REQ-004 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port: in_valid  input  1  upstream link offers a flit.
REQ-007 Port: in_ready  output  1  FIFO can accept a flit this cycle.
REQ-008 Port: in_data  input  WIDTH  incoming flit.
REQ-009 Port: out_valid  output  1  flit available to the downstream pipeline register.
REQ-010 Port: out_ready  input  1  downstream accepts the head flit this cycle.
REQ-011 Port: out_data  output  WIDTH  head flit.
REQ-012 Port: credit_out  output  1  one-cycle pulse per flit dequeued, returned upstream.
REQ-013 Port: count  output  CW  current occupancy.
REQ-014 Port: overflow_err  output  1  sticky flag: flit offered while in_ready low.

Function
REQ-015 Storage: circular buffer of DEPTH entries; wr_ptr, rd_ptr, count registers.
REQ-016 Push: in_valid & in_ready; writes in_data at wr_ptr; wr_ptr advances.
REQ-017 Pop: out_valid & out_ready; rd_ptr advances; credit_out = 1 in the following cycle, registered.
REQ-018 Pointer wrap: DEPTH-1 -> 0 for both pointers.
REQ-019 in_ready = (count != DEPTH); no push-through when full, even with a simultaneous pop.
REQ-020 out_valid = (count != 0); out_data = mem[rd_ptr]; both are combinational from registered state.
REQ-021 Latency: a pushed flit is visible on out_* one cycle after the push edge at the earliest.
REQ-022 Simultaneous push and pop: both take effect; count unchanged.
REQ-023 Empty FIFO with out_ready high: no pop and no credit.
REQ-024 Full FIFO: in_ready low; an offered flit is dropped and overflow_err sets; contents untouched.
REQ-025 overflow_err clears only on reset.
REQ-026 Order: strict FIFO; no flit is duplicated, reordered or lost, except the flits dropped under REQ-024.
REQ-027 Data stability: out_data holds its value while out_valid & !out_ready.

Reset
REQ-028 On clk edge with rst_n low:
  - wr_ptr, rd_ptr, count, credit_out and overflow_err clear to 0;
  - hence out_valid = 0, in_ready = 1.
REQ-029 Storage array is not reset; its contents are don't-care.
REQ-030 Reset mid-operation discards all stored flits and any pending credit; no credit_out pulse is emitted for the discarded flits.

Configuration
REQ-031 Macro NW_FLIT_FIFO_BYPASS_EN enables the bypass path.
REQ-032 With the macro, bypass applies when count == 0 and in_valid high:
  - out_valid = 1 and out_data = in_data combinationally;
  - if out_ready is also high, the flit is consumed without being stored, count stays 0, and credit_out pulses next cycle;
  - if out_ready is low, the flit is stored normally.
REQ-033 Without the macro: no combinational path from in_* to out_*; REQ-021 latency applies.

Verification
REQ-034 DEPTH=4, WIDTH=8: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0, out_data=0x11.
REQ-035 From full: out_ready=1 for 4 cycles -> pops 0x11,0x22,0x33,0x44 in order, four credit_out pulses each one cycle after its pop, then count=0, out_valid=0.
REQ-036 count=2, continuous push and pop for 10 cycles -> count stays 2, pointers wrap, output sequence equals input sequence.
REQ-037 Full, in_valid=1 with data 0x55 -> 0x55 is never output, overflow_err=1 and remains 1 until rst_n low.
REQ-038 Two flits stored, rst_n low for 1 cycle -> count=0, out_valid=0, credit_out=0, overflow_err=0; next push of 0x66 is output first.
REQ-039 Empty, in_valid=1 with 0x77 and out_ready=1:
  - with NW_FLIT_FIFO_BYPASS_EN: out_data=0x77 same cycle, count stays 0;
  - without it: 0x77 appears next cycle.
